// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one ready/request memory port, with sticky trap flags.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR | ALUOut <= rs1+imm
// MEMRD  | load data read at ALUOut
// MEMWB  | rd <= memory data register
// MEMWR  | store write at ALUOut
// EXECR  | ALUOut <= rs1 op rs2
// EXECI  | ALUOut <= rs1 op imm (or passB for LUI)
// ALUWB  | rd <= ALUOut
// BRANCH | compare rs1/rs2, PC <= ALUOut when taken
// JAL    | PC <= ALUOut, ALUOut <= OldPC+4
// TRAP   | all enables off until reset
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit BRANCH_FULL    = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_result_src,
    output logic [3:0] o_alu_control,
    output logic       o_illegal,
    output logic       o_bus_error,
    output logic [3:0] o_state
);

    localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                           S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                           S_EXECR  = 4'd6,  S_EXECI  = 4'd7,  S_ALUWB  = 4'd8,
                           S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_TRAP   = 4'd15;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_R     = 7'b0110011, OP_IMM   = 7'b0010011,
                           OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [3:0]       r_state;
    logic             r_illegal;
    logic             r_bus_error;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [3:0] w_next;
    logic       w_set_ill;
    logic       w_set_bus;
    logic       w_timeout;
    logic       w_f7_ok;
    logic       w_shift_imm;
    logic       w_br_ok;
    logic       w_taken;
    logic [3:0] w_alu_op;

    assign w_f7_ok     = (i_funct7 == 7'b0000000) || (i_funct7 == 7'b0100000);
    assign w_shift_imm = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign w_br_ok     = BRANCH_FULL ? ((i_funct3 != 3'b010) && (i_funct3 != 3'b011))
                                     : ((i_funct3 == 3'b000) || (i_funct3 == 3'b100));

    // The counter holds the number of low cycles already seen, so the access that
    // is low again at count TIMEOUT-1 is the one that exhausts the budget.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !i_mem_ready &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_taken = 1'b0;
        case (i_funct3)
            3'b000:  w_taken = i_zero;
            3'b001:  w_taken = !i_zero;
            3'b100:  w_taken = i_lt;
            3'b101:  w_taken = !i_lt;
            3'b110:  w_taken = i_ltu;
            3'b111:  w_taken = !i_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_op = ALU_ADD;
        case (i_funct3)
            3'b000:  w_alu_op = ((i_opcode == OP_R) && i_funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_op = ALU_SLL;
            3'b010:  w_alu_op = ALU_SLT;
            3'b011:  w_alu_op = ALU_SLTU;
            3'b100:  w_alu_op = ALU_XOR;
            3'b101:  w_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
        endcase
        if (i_opcode == OP_LUI) w_alu_op = ALU_PASSB;
    end

    always_comb begin
        w_next    = r_state;
        w_set_ill = 1'b0;
        w_set_bus = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (i_mem_ready)    w_next = S_DECODE;
                else if (w_timeout) begin w_next = S_TRAP; w_set_bus = 1'b1; end
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = w_f7_ok ? S_EXECR : S_TRAP;
                    OP_IMM:            w_next = (w_shift_imm && !w_f7_ok) ? S_TRAP : S_EXECI;
                    OP_LUI:            w_next = S_EXECI;
                    OP_AUIPC:          w_next = S_ALUWB;
                    OP_BR:             w_next = w_br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_TRAP;
                endcase
                w_set_ill = (w_next == S_TRAP);
            end
            S_MEMADR: w_next = (i_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (i_mem_ready)    w_next = S_MEMWB;
                else if (w_timeout) begin w_next = S_TRAP; w_set_bus = 1'b1; end
            end
            S_MEMWR: begin
                if (i_mem_ready)    w_next = S_FETCH;
                else if (w_timeout) begin w_next = S_TRAP; w_set_bus = 1'b1; end
            end
            S_MEMWB, S_ALUWB, S_BRANCH: w_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL:    w_next = (r_state == S_JAL) ? S_ALUWB : S_ALUWB;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_adr_src     = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_result_src  = 2'b00;
        o_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                // Reset forces FETCH, but nothing may be loaded while it is held.
                o_ir_write   = i_mem_ready && i_rst_n;
                o_pc_write   = i_mem_ready && i_rst_n;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                o_mem_req = 1'b1;
                o_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_result_src = 2'b01;
            end
            S_MEMWR: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_adr_src = 1'b1;
            end
            S_EXECR: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = w_alu_op;
            end
            S_EXECI: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b01;
                o_alu_control = w_alu_op;
            end
            S_ALUWB: o_reg_write = 1'b1;
            S_BRANCH: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = ALU_SUB;
                o_pc_write    = w_taken;
            end
            S_JAL: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                o_pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_FETCH;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_ill) r_illegal   <= 1'b1;
            if (w_set_bus) r_bus_error <= 1'b1;
            if (w_next != r_state)  r_wait_cnt <= '0;
            else if (!i_mem_ready)  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign o_state     = r_state;
    assign o_illegal   = r_illegal;
    assign o_bus_error = r_bus_error;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default build, a BRANCH_FULL=0/TIMEOUT=4
// build and a TIMEOUT=0 build, all checked against hand-computed values.
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_IMM = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       zero, lt, ltu;

    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control, state;
    logic       illegal, bus_error;

    logic [15:0] misc_b, misc_c;
    logic [3:0]  state_b, state_c;
    logic        illegal_b, bus_error_b, illegal_c, bus_error_c;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller u_dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_zero(zero), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(rdy_a),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_adr_src(adr_src), .o_ir_write(ir_write),
        .o_pc_write(pc_write), .o_reg_write(reg_write), .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b), .o_result_src(result_src), .o_alu_control(alu_control),
        .o_illegal(illegal), .o_bus_error(bus_error), .o_state(state)
    );

    multicycle_controller #(.TIMEOUT_CYCLES(4), .BRANCH_FULL(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_zero(zero), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(rdy_b),
        .o_mem_req(misc_b[0]), .o_mem_we(misc_b[1]), .o_adr_src(misc_b[2]), .o_ir_write(misc_b[3]),
        .o_pc_write(misc_b[4]), .o_reg_write(misc_b[5]), .o_alu_src_a(misc_b[7:6]),
        .o_alu_src_b(misc_b[9:8]), .o_result_src(misc_b[11:10]), .o_alu_control(misc_b[15:12]),
        .o_illegal(illegal_b), .o_bus_error(bus_error_b), .o_state(state_b)
    );

    multicycle_controller #(.TIMEOUT_CYCLES(0), .BRANCH_FULL(1'b1)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_zero(zero), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(rdy_c),
        .o_mem_req(misc_c[0]), .o_mem_we(misc_c[1]), .o_adr_src(misc_c[2]), .o_ir_write(misc_c[3]),
        .o_pc_write(misc_c[4]), .o_reg_write(misc_c[5]), .o_alu_src_a(misc_c[7:6]),
        .o_alu_src_b(misc_c[9:8]), .o_result_src(misc_c[11:10]), .o_alu_control(misc_c[15:12]),
        .o_illegal(illegal_c), .o_bus_error(bus_error_c), .o_state(state_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        rdy_a = 1'b1;
        tick();
        rst_a = 1'b1;
        #1;
    endtask

    // Starts in FETCH with mem_ready high; checks the execute state and its ALU op.
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int exp_st, input int exp_alu);
        opcode = op; funct3 = f3; funct7 = f7; rdy_a = 1'b1;
        tick();
        tick();
        chk({tag, "_state"}, 32'(state), exp_st);
        chk({tag, "_alu"}, 32'(alu_control), exp_alu);
        tick();
        chk({tag, "_wb"}, 32'(state), 8);
        tick();
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                          input logic l, input logic lu, input int exp_taken);
        opcode = OP_BR; funct3 = f3; funct7 = 7'd0; zero = z; lt = l; ltu = lu; rdy_a = 1'b1;
        tick();
        tick();
        chk({tag, "_state"}, 32'(state), 9);
        chk({tag, "_pc_write"}, 32'(pc_write), exp_taken);
        tick();
        chk({tag, "_back"}, 32'(state), 0);
    endtask

    task automatic expect_trap(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7);
        reset_a();
        opcode = op; funct3 = f3; funct7 = f7;
        tick();
        tick();
        chk({tag, "_state"}, 32'(state), 15);
        chk({tag, "_illegal"}, 32'(illegal), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b0; rdy_c = 1'b0;
        opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0100000;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_bus_error", 32'(bus_error), 0);
        chk("rst_mem_req", 32'(mem_req), 1);
        chk("rst_ir_write", 32'(ir_write), 0);
        chk("rst_pc_write", 32'(pc_write), 0);

        rst_a = 1'b1;
        #1;
        chk("fetch_ir_write", 32'(ir_write), 1);
        chk("fetch_pc_write", 32'(pc_write), 1);
        chk("fetch_src_b", 32'(alu_src_b), 2);
        chk("fetch_result_src", 32'(result_src), 2);

        // R-type sub: 0,1,6,8,0
        tick();
        chk("sub_dec_state", 32'(state), 1);
        chk("sub_dec_src_a", 32'(alu_src_a), 1);
        chk("sub_dec_src_b", 32'(alu_src_b), 1);
        chk("sub_dec_enables", 32'({mem_req, ir_write, pc_write, reg_write}), 0);
        tick();
        chk("sub_exec_state", 32'(state), 6);
        chk("sub_exec_alu", 32'(alu_control), 1);
        chk("sub_exec_src_a", 32'(alu_src_a), 2);
        chk("sub_exec_src_b", 32'(alu_src_b), 0);
        chk("sub_exec_reg_write", 32'(reg_write), 0);
        tick();
        chk("sub_wb_state", 32'(state), 8);
        chk("sub_wb_reg_write", 32'(reg_write), 1);
        chk("sub_wb_result_src", 32'(result_src), 0);
        tick();
        chk("sub_back_state", 32'(state), 0);

        run_alu("r_add",  OP_R, 3'b000, 7'b0000000, 6, 0);
        run_alu("r_sll",  OP_R, 3'b001, 7'b0000000, 6, 7);
        run_alu("r_slt",  OP_R, 3'b010, 7'b0000000, 6, 5);
        run_alu("r_sltu", OP_R, 3'b011, 7'b0000000, 6, 6);
        run_alu("r_xor",  OP_R, 3'b100, 7'b0000000, 6, 4);
        run_alu("r_srl",  OP_R, 3'b101, 7'b0000000, 6, 8);
        run_alu("r_sra",  OP_R, 3'b101, 7'b0100000, 6, 9);
        run_alu("r_or",   OP_R, 3'b110, 7'b0000000, 6, 3);
        run_alu("r_and",  OP_R, 3'b111, 7'b0000000, 6, 2);
        run_alu("i_addi", OP_IMM, 3'b000, 7'b1010101, 7, 0);
        run_alu("i_srai", OP_IMM, 3'b101, 7'b0100000, 7, 9);
        run_alu("i_srli", OP_IMM, 3'b101, 7'b0000000, 7, 8);
        run_alu("i_andi", OP_IMM, 3'b111, 7'b1111111, 7, 2);
        run_alu("lui",    OP_LUI, 3'b101, 7'b0100000, 7, 10);

        // Load with three low cycles in MEMRD
        opcode = OP_LOAD; funct3 = 3'b010; funct7 = 7'd0; rdy_a = 1'b1;
        tick();
        tick();
        chk("ld_adr_state", 32'(state), 2);
        chk("ld_adr_srcs", 32'({alu_src_a, alu_src_b}), 4'b1001);
        rdy_a = 1'b0;
        tick();
        chk("ld_rd_state", 32'(state), 3);
        chk("ld_rd_req", 32'({mem_req, adr_src, mem_we}), 3'b110);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_wait_state", 32'(state), 3);
        end
        rdy_a = 1'b1;
        tick();
        chk("ld_wb_state", 32'(state), 4);
        chk("ld_wb_reg_write", 32'(reg_write), 1);
        chk("ld_wb_result_src", 32'(result_src), 1);
        tick();
        chk("ld_back_state", 32'(state), 0);

        opcode = OP_STORE;
        tick();
        tick();
        chk("st_adr_state", 32'(state), 2);
        tick();
        chk("st_wr_state", 32'(state), 5);
        chk("st_wr_req", 32'({mem_req, mem_we, adr_src, reg_write}), 4'b1110);
        tick();
        chk("st_back_state", 32'(state), 0);

        run_br("beq_t",  3'b000, 1'b1, 1'b0, 1'b0, 1);
        run_br("beq_n",  3'b000, 1'b0, 1'b1, 1'b1, 0);
        run_br("bne_t",  3'b001, 1'b0, 1'b0, 1'b0, 1);
        run_br("bne_n",  3'b001, 1'b1, 1'b0, 1'b0, 0);
        run_br("blt_t",  3'b100, 1'b0, 1'b1, 1'b0, 1);
        run_br("bge_n",  3'b101, 1'b0, 1'b1, 1'b0, 0);
        run_br("bltu_t", 3'b110, 1'b0, 1'b0, 1'b1, 1);
        run_br("bgeu_n", 3'b111, 1'b0, 1'b0, 1'b1, 0);
        run_br("bgeu_t", 3'b111, 1'b0, 1'b1, 1'b0, 1);

        opcode = OP_AUIPC;
        tick();
        tick();
        chk("auipc_wb_state", 32'(state), 8);
        chk("auipc_reg_write", 32'(reg_write), 1);
        tick();
        chk("auipc_back_state", 32'(state), 0);

        opcode = OP_JAL;
        tick();
        tick();
        chk("jal_state", 32'(state), 10);
        chk("jal_ctrl", 32'({pc_write, alu_src_a, alu_src_b, result_src}), 7'b1011000);
        tick();
        chk("jal_wb_state", 32'(state), 8);
        chk("jal_wb_reg_write", 32'(reg_write), 1);
        tick();
        chk("jal_back_state", 32'(state), 0);

        // Reset in the middle of a stalled load
        opcode = OP_LOAD;
        tick();
        tick();
        rdy_a = 1'b0;
        tick();
        tick();
        chk("mid_rd_state", 32'(state), 3);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_flags", 32'({illegal, bus_error}), 0);
        chk("mid_rst_mem_req", 32'(mem_req), 1);
        rdy_a = 1'b1;
        #1;
        chk("mid_rst_ir_write", 32'(ir_write), 0);
        rst_a = 1'b1;
        #1;
        chk("mid_rel_ir_write", 32'(ir_write), 1);
        chk("mid_rel_pc_write", 32'(pc_write), 1);

        expect_trap("r_bad_f7",    OP_R,   3'b000, 7'b0000001);
        expect_trap("slli_bad_f7", OP_IMM, 3'b001, 7'b0000001);
        expect_trap("br_f3_010",   OP_BR,  3'b010, 7'b0000000);
        expect_trap("undef_op",    7'b1111111, 3'b000, 7'b0000000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("trap_hold_state", 32'(state), 15);
            chk("trap_hold_enables", 32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 0);
            chk("trap_hold_illegal", 32'({illegal, bus_error}), 2'b10);
        end
        reset_a();
        chk("trap_cleared", 32'({illegal, state}), 0);
        rst_a = 1'b0;

        // BRANCH_FULL=0, TIMEOUT_CYCLES=4
        opcode = OP_BR; funct3 = 3'b000; zero = 1'b1;
        rdy_b = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        chk("b_beq_state", 32'(state_b), 9);
        chk("b_beq_pc_write", 32'(misc_b[4]), 1);
        funct3 = 3'b001;
        tick();
        tick();
        tick();
        chk("b_bne_state", 32'(state_b), 15);
        chk("b_bne_illegal", 32'(illegal_b), 1);
        rst_b = 1'b0;
        rdy_b = 1'b0;
        tick();
        chk("b_rst_illegal", 32'(illegal_b), 0);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_wait_state", 32'(state_b), 0);
            chk("b_wait_bus_error", 32'(bus_error_b), 0);
        end
        tick();
        chk("b_timeout_state", 32'(state_b), 15);
        chk("b_timeout_bus_error", 32'(bus_error_b), 1);
        chk("b_timeout_illegal", 32'(illegal_b), 0);
        rst_b = 1'b0;

        // TIMEOUT_CYCLES=0 never times out
        rst_c = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("c_wait_state", 32'(state_c), 0);
        end
        chk("c_bus_error", 32'(bus_error_c), 0);
        chk("c_mem_req", 32'(misc_c[0]), 1);
        rdy_c = 1'b1;
        #1;
        chk("c_ir_write", 32'(misc_c[3]), 1);
        tick();
        chk("c_decode_state", 32'(state_c), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
